// File: rtl/pcie_irq_pkg.sv
// ----------------------------------------------------------------------------
// pcie_irq_pkg : shared types and constants for the PCIe interrupt controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pcie_irq_pkg;

   localparam int MAX_SRC = 32;
   localparam int VEC_W   = 8;
   localparam int IDX_W   = $clog2(MAX_SRC);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      MSI_REQ    = 3'd1,
      HOLDOFF    = 3'd2,
      INTX_ASR   = 3'd3,
      INTX_ON    = 3'd4,
      INTX_DEASR = 3'd5
   } irq_state_t;

   // Vector number is truncated to the number of vectors the host allocated.
   function automatic logic [VEC_W-1:0] msi_vector(input logic [IDX_W-1:0] idx,
                                                   input logic [2:0]       mmen);
      return VEC_W'(idx) & ((VEC_W'(1) << mmen) - VEC_W'(1));
   endfunction

endpackage

`default_nettype wire

// File: rtl/pcie_irq_ctrl_if.sv
// ----------------------------------------------------------------------------
// pcie_irq_ctrl_if : cfg_interrupt handshake between controller and PCIe core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pcie_irq_ctrl_if;
   import pcie_irq_pkg::*;

   logic             cfg_interrupt_n_o;
   logic             cfg_interrupt_assert_n_o;
   logic [VEC_W-1:0] cfg_interrupt_di_o;
   logic             cfg_interrupt_rdy_n_i;
   logic             cfg_interrupt_msienable_i;
   logic [2:0]       cfg_interrupt_mmenable_i;

   modport master (
      output cfg_interrupt_n_o,
      output cfg_interrupt_assert_n_o,
      output cfg_interrupt_di_o,
      input  cfg_interrupt_rdy_n_i,
      input  cfg_interrupt_msienable_i,
      input  cfg_interrupt_mmenable_i
   );

   modport slave (
      input  cfg_interrupt_n_o,
      input  cfg_interrupt_assert_n_o,
      input  cfg_interrupt_di_o,
      output cfg_interrupt_rdy_n_i,
      output cfg_interrupt_msienable_i,
      output cfg_interrupt_mmenable_i
   );

endinterface

`default_nettype wire

// File: rtl/pcie_irq_rr_arb.sv
// ----------------------------------------------------------------------------
// pcie_irq_rr_arb : round-robin search of a request vector starting at ptr
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pcie_irq_rr_arb
   import pcie_irq_pkg::*;
#(
   parameter int N_SRC = 4
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] grant,
   output logic             valid
);

   localparam int CW = IDX_W + 1;

   logic [CW-1:0]    cand;
   logic [N_SRC-1:0] shifted;

   // Walk from the farthest offset back to ptr so the nearest request wins.
   always_comb begin
      grant   = '0;
      valid   = 1'b0;
      cand    = '0;
      shifted = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + CW'(k);
         if (cand >= CW'(N_SRC)) begin
            cand = cand - CW'(N_SRC);
         end
         shifted = req >> cand;
         if (shifted[0]) begin
            grant = cand[IDX_W-1:0];
            valid = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pcie_irq_ctrl.sv
// ----------------------------------------------------------------------------
// pcie_irq_ctrl : pending-bit collector driving MSI or legacy INTx signalling
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pcie_irq_ctrl
   import pcie_irq_pkg::*;
#(
   parameter int N_SRC  = 4,
   parameter int HOLD_W = 16
) (
   input  logic              trn_clk_c,
   input  logic              pio_reset_n,
   pcie_irq_ctrl_if.master   cfg,
   input  logic [N_SRC-1:0]  irq_src_i,
   input  logic [N_SRC-1:0]  irq_mask_i,
   input  logic [N_SRC-1:0]  irq_ack_i,
   input  logic [HOLD_W-1:0] holdoff_i,
   input  logic              intx_disable_i,
   output logic [N_SRC-1:0]  irq_pending_o,
   output logic [15:0]       msi_sent_cnt_o
);

   irq_state_t        state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  winner;
   logic [HOLD_W-1:0] hold_cnt;
   logic [N_SRC-1:0]  pending;
   logic [N_SRC-1:0]  eligible;
   logic [N_SRC-1:0]  clr;
   logic [IDX_W-1:0]  grant;
   logic              grant_vld;
   logic              msi_accept;
   logic              int_n;
   logic              assert_n;
   logic [VEC_W-1:0]  di;
   logic [15:0]       sent_cnt;

   assign eligible   = pending & ~irq_mask_i;
   assign msi_accept = (state == MSI_REQ) && !cfg.cfg_interrupt_rdy_n_i;

   always_comb begin
      clr = irq_ack_i;
      if (msi_accept) begin
         clr = clr | (N_SRC'(1) << winner);
      end
   end

   pcie_irq_rr_arb #(
      .N_SRC (N_SRC)
   ) u_arb (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (grant),
      .valid (grant_vld)
   );

   // A new event in the same cycle as a clear keeps the bit set.
   always_ff @(posedge trn_clk_c or negedge pio_reset_n) begin
      if (!pio_reset_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr) | irq_src_i;
      end
   end

   always_ff @(posedge trn_clk_c or negedge pio_reset_n) begin
      if (!pio_reset_n) begin
         state    <= IDLE;
         int_n    <= 1'b1;
         assert_n <= 1'b1;
         di       <= '0;
         winner   <= '0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         sent_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld && cfg.cfg_interrupt_msienable_i) begin
                  winner <= grant;
                  di     <= msi_vector(grant, cfg.cfg_interrupt_mmenable_i);
                  int_n  <= 1'b0;
                  state  <= MSI_REQ;
               end else if (grant_vld && !intx_disable_i) begin
                  int_n    <= 1'b0;
                  assert_n <= 1'b0;
                  state    <= INTX_ASR;
               end
            end
            MSI_REQ: begin
               if (!cfg.cfg_interrupt_rdy_n_i) begin
                  int_n    <= 1'b1;
                  sent_cnt <= sent_cnt + 16'd1;
                  rr_ptr   <= (winner == IDX_W'(N_SRC - 1)) ? '0 : winner + IDX_W'(1);
                  if (holdoff_i == '0) begin
                     state <= IDLE;
                  end else begin
                     hold_cnt <= holdoff_i;
                     state    <= HOLDOFF;
                  end
               end
            end
            HOLDOFF: begin
               if (hold_cnt <= HOLD_W'(1)) begin
                  hold_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            INTX_ASR: begin
               if (!cfg.cfg_interrupt_rdy_n_i) begin
                  int_n    <= 1'b1;
                  assert_n <= 1'b1;
                  state    <= INTX_ON;
               end
            end
            INTX_ON: begin
               if ((eligible == '0) || cfg.cfg_interrupt_msienable_i || intx_disable_i) begin
                  int_n <= 1'b0;
                  state <= INTX_DEASR;
               end
            end
            INTX_DEASR: begin
               if (!cfg.cfg_interrupt_rdy_n_i) begin
                  int_n <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               int_n    <= 1'b1;
               assert_n <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign cfg.cfg_interrupt_n_o        = int_n;
   assign cfg.cfg_interrupt_assert_n_o = assert_n;
   assign cfg.cfg_interrupt_di_o       = di;
   assign irq_pending_o                = pending;
   assign msi_sent_cnt_o               = sent_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pcie_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pcie_irq_ctrl : scoreboard bench acting as the PCIe core for pcie_irq_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pcie_irq_ctrl;

   localparam logic [1:0] K_MSI   = 2'd0;
   localparam logic [1:0] K_ASR   = 2'd1;
   localparam logic [1:0] K_DEASR = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] di;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  irq_src;
   logic [3:0]  irq_mask;
   logic [3:0]  irq_ack;
   logic [15:0] holdoff;
   logic        intx_disable;
   logic [3:0]  irq_pending;
   logic [15:0] msi_cnt;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   pcie_irq_ctrl_if cfg_if ();

   pcie_irq_ctrl #(
      .N_SRC  (4),
      .HOLD_W (16)
   ) dut (
      .trn_clk_c      (clk),
      .pio_reset_n    (rst_n),
      .cfg            (cfg_if),
      .irq_src_i      (irq_src),
      .irq_mask_i     (irq_mask),
      .irq_ack_i      (irq_ack),
      .holdoff_i      (holdoff),
      .intx_disable_i (intx_disable),
      .irq_pending_o  (irq_pending),
      .msi_sent_cnt_o (msi_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] kind, input logic [7:0] di);
      exp_t e;
      e.kind = kind;
      e.di   = di;
      sb.push_back(e);
   endtask

   task automatic pulse_src(input logic [3:0] v);
      irq_src = v;
      @(negedge clk);
      irq_src = 4'd0;
   endtask

   task automatic quiet(input int n, input string tag);
      int lows;
      lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (cfg_if.cfg_interrupt_n_o !== 1'b1) lows++;
      end
      check_val(tag, lows, 0);
   endtask

   // Core model: wait for a request, hold rdy off for 'delay' cycles, then accept.
   task automatic serve(input int delay, input logic [3:0] src_at_ack);
      int         waited;
      logic       stable;
      logic [7:0] di0;
      logic       asn0;
      exp_t       e;
      waited = 0;
      while (cfg_if.cfg_interrupt_n_o !== 1'b0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check_val("req_seen", (waited < 200), 1);
      if (waited >= 200) return;
      di0  = cfg_if.cfg_interrupt_di_o;
      asn0 = cfg_if.cfg_interrupt_assert_n_o;
      check_val("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check_val("assert_n", asn0, (e.kind == K_ASR) ? 1'b0 : 1'b1);
      if (e.kind == K_MSI) check_val("msi_di", di0, e.di);
      stable = 1'b1;
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         if (cfg_if.cfg_interrupt_n_o !== 1'b0 || cfg_if.cfg_interrupt_di_o !== di0 ||
             cfg_if.cfg_interrupt_assert_n_o !== asn0) stable = 1'b0;
      end
      check_val("req_held", stable, 1);
      cfg_if.cfg_interrupt_rdy_n_i = 1'b0;
      irq_src = src_at_ack;
      @(negedge clk);
      cfg_if.cfg_interrupt_rdy_n_i = 1'b1;
      irq_src = 4'd0;
      check_val("req_release", cfg_if.cfg_interrupt_n_o, 1);
      check_val("assert_n_idle", cfg_if.cfg_interrupt_assert_n_o, 1);
   endtask

   initial begin
      int idle;
      int waited;
      rst_n        = 1'b0;
      irq_src      = '0;
      irq_mask     = '0;
      irq_ack      = '0;
      holdoff      = '0;
      intx_disable = 1'b0;
      cfg_if.cfg_interrupt_rdy_n_i     = 1'b1;
      cfg_if.cfg_interrupt_msienable_i = 1'b1;
      cfg_if.cfg_interrupt_mmenable_i  = 3'd2;
      repeat (3) @(negedge clk);
      check_val("rst_int_n", cfg_if.cfg_interrupt_n_o, 1);
      check_val("rst_assert_n", cfg_if.cfg_interrupt_assert_n_o, 1);
      check_val("rst_di", cfg_if.cfg_interrupt_di_o, 0);
      check_val("rst_pending", irq_pending, 0);
      check_val("rst_cnt", msi_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Masked source latches pending but is not signalled until unmasked.
      irq_mask = 4'b1000;
      pulse_src(4'b1000);
      quiet(10, "masked_quiet");
      check_val("masked_pending", irq_pending, 4'b1000);
      irq_mask = 4'b0000;
      push_exp(K_MSI, 8'd3);
      serve(3, 4'd0);
      check_val("msi3_pending", irq_pending, 0);
      check_val("msi3_cnt", msi_cnt, 1);

      // Two simultaneous sources, holdoff gap, vectors collapse to 0.
      cfg_if.cfg_interrupt_mmenable_i = 3'd0;
      holdoff = 16'd5;
      pulse_src(4'b0101);
      push_exp(K_MSI, 8'd0);
      push_exp(K_MSI, 8'd0);
      serve(1, 4'd0);
      check_val("rr_first_pending", irq_pending, 4'b0100);
      idle = 0;
      while (cfg_if.cfg_interrupt_n_o === 1'b1 && idle < 100) begin
         idle++;
         @(negedge clk);
      end
      check_val("holdoff_gap", (idle >= 5), 1);
      serve(0, 4'd0);
      check_val("rr_pending", irq_pending, 0);
      check_val("rr_cnt", msi_cnt, 3);
      quiet(8, "holdoff_settle");

      // New event in the acceptance cycle keeps the bit pending.
      holdoff = 16'd0;
      cfg_if.cfg_interrupt_mmenable_i = 3'd3;
      pulse_src(4'b0010);
      push_exp(K_MSI, 8'd1);
      push_exp(K_MSI, 8'd1);
      serve(1, 4'b0010);
      check_val("race_pending", irq_pending[1], 1);
      serve(0, 4'd0);
      check_val("race_cleared", irq_pending, 0);
      check_val("race_cnt", msi_cnt, 5);

      // Legacy INTx assert / ack / deassert.
      cfg_if.cfg_interrupt_msienable_i = 1'b0;
      @(negedge clk);
      pulse_src(4'b0100);
      push_exp(K_ASR, 8'd0);
      serve(2, 4'd0);
      quiet(5, "intx_on_quiet");
      check_val("intx_pending", irq_pending, 4'b0100);
      irq_ack = 4'b0100;
      @(negedge clk);
      irq_ack = 4'b0000;
      push_exp(K_DEASR, 8'd0);
      serve(2, 4'd0);
      check_val("intx_cleared", irq_pending, 0);
      check_val("intx_cnt", msi_cnt, 5);
      quiet(3, "intx_idle");

      // Mode switch while INTx asserted: deassert first, then MSI.
      pulse_src(4'b0010);
      push_exp(K_ASR, 8'd0);
      serve(1, 4'd0);
      cfg_if.cfg_interrupt_msienable_i = 1'b1;
      push_exp(K_DEASR, 8'd0);
      push_exp(K_MSI, 8'd1);
      serve(2, 4'd0);
      serve(1, 4'd0);
      check_val("switch_pending", irq_pending, 0);
      check_val("switch_cnt", msi_cnt, 6);
      quiet(3, "switch_idle");

      // Reset in the middle of an MSI handshake.
      cfg_if.cfg_interrupt_mmenable_i = 3'd2;
      pulse_src(4'b0001);
      waited = 0;
      while (cfg_if.cfg_interrupt_n_o !== 1'b0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check_val("rst_req_seen", (waited < 50), 1);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check_val("mid_rst_int_n", cfg_if.cfg_interrupt_n_o, 1);
      check_val("mid_rst_assert_n", cfg_if.cfg_interrupt_assert_n_o, 1);
      check_val("mid_rst_di", cfg_if.cfg_interrupt_di_o, 0);
      check_val("mid_rst_pending", irq_pending, 0);
      check_val("mid_rst_cnt", msi_cnt, 0);
      rst_n = 1'b1;
      quiet(20, "no_replay");
      check_val("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pcie_irq_ctrl.md
PCIE_IRQ_CTRL -- requirements
Module: pcie_irq_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of interrupt sources (legal 1..32).
REQ-002 SHALL have parameter HOLD_W, default 16, width of the inter-message holdoff counter.
REQ-003 SHALL have port trn_clk_c, in, 1, core TRN clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port pio_reset_n, in, 1, asynchronous active-low reset.
REQ-005 SHALL have port irq_src_i, in, N_SRC, per-source request; any high cycle is an event.
REQ-006 SHALL have port irq_mask_i, in, N_SRC, 1 = source not eligible for signalling.
REQ-007 SHALL have port irq_ack_i, in, N_SRC, host write-1-to-clear for pending bits.
REQ-008 SHALL have port holdoff_i, in, HOLD_W, minimum idle cycles between MSI messages.
REQ-009 SHALL have port cfg_interrupt_msienable_i, in, 1, from core; 1 = MSI, 0 = legacy INTx.
REQ-010 SHALL have port cfg_interrupt_mmenable_i, in, 3, from core; number of allocated vectors is 2^value.
REQ-011 SHALL have port intx_disable_i, in, 1, Command register bit 10.
REQ-012 SHALL have port cfg_interrupt_rdy_n_i, in, 1, core handshake acknowledge, active-low.
REQ-013 SHALL have port cfg_interrupt_n_o, out, 1, core interrupt request, active-low.
REQ-014 SHALL have port cfg_interrupt_assert_n_o, out, 1, INTx assert (0) or deassert (1) qualifier.
REQ-015 SHALL have port cfg_interrupt_di_o, out, 8, MSI vector number.
REQ-016 SHALL have port irq_pending_o, out, N_SRC, pending bits.
REQ-017 SHALL have port msi_sent_cnt_o, out, 16, count of accepted MSI messages.

Function
REQ-018 SHALL set pending[i] on any cycle in which irq_src_i[i]=1, regardless of mask.
REQ-019 SHALL clear pending[i] on irq_ack_i[i]=1, and on MSI acceptance of source i; if set and clear coincide, set SHALL win.
REQ-020 SHALL treat source i as eligible when pending[i]=1 and irq_mask_i[i]=0.
REQ-021 SHALL select among eligible sources round-robin, starting at the index after the last source served; after reset the search starts at index 0.
REQ-022 SHALL use FSM states IDLE, MSI_REQ, HOLDOFF, INTX_ASR, INTX_ON and INTX_DEASR.
REQ-023 IDLE -> MSI_REQ when msienable=1 and at least one source is eligible; the winner index and cfg_interrupt_di_o = index AND (2^mmenable - 1) SHALL be registered, and cfg_interrupt_n_o=0 SHALL appear on the next cycle.
REQ-024 MSI_REQ SHALL hold cfg_interrupt_n_o=0 and cfg_interrupt_di_o stable until the cycle in which cfg_interrupt_rdy_n_i=0; in that cycle it SHALL clear the winner's pending bit and increment msi_sent_cnt_o, which wraps at 16 bits.
REQ-025 On acceptance, cfg_interrupt_n_o SHALL return to 1 on the next cycle and the FSM SHALL enter HOLDOFF, counting holdoff_i cycles before IDLE; holdoff_i=0 SHALL go directly to IDLE, giving 1 idle cycle minimum.
REQ-026 IDLE -> INTX_ASR when msienable=0, intx_disable_i=0 and at least one source is eligible; INTX_ASR SHALL drive cfg_interrupt_n_o=0 and cfg_interrupt_assert_n_o=0 until rdy, then enter INTX_ON with cfg_interrupt_n_o=1.
REQ-027 In INTX_ON, pending bits SHALL be cleared only by irq_ack_i; the FSM SHALL move to INTX_DEASR when no source is eligible, or when msienable=1, or when intx_disable_i=1.
REQ-028 INTX_DEASR SHALL drive cfg_interrupt_n_o=0 and cfg_interrupt_assert_n_o=1 until rdy, then return to IDLE.
REQ-029 An asserted request SHALL never be withdrawn before rdy, including when the mode changes, the mask changes or an ack arrives mid-handshake.
REQ-030 All outputs SHALL be registered; cfg_interrupt_assert_n_o SHALL be 1 outside INTX_ASR.

Reset
REQ-031 On pio_reset_n=0 the block SHALL asynchronously enter IDLE with cfg_interrupt_n_o=1, cfg_interrupt_assert_n_o=1, cfg_interrupt_di_o=0, irq_pending_o=0, msi_sent_cnt_o=0, the holdoff counter at 0 and the round-robin pointer at 0.
REQ-032 Reset asserted mid-handshake SHALL abort the handshake; the lost request is not replayed after reset.

Structure
REQ-033 Package pcie_irq_pkg SHALL hold the FSM state type, MAX_SRC=32 and VEC_W=8.
REQ-034 Round-robin selection SHALL be a sub-module, pcie_irq_rr_arb (inputs: request vector and pointer; outputs: grant index and valid).

Verification
REQ-035 MSI mode, mmenable=2, src[3] pulses, rdy after 3 cycles -> one request with di=3, pending[3] cleared, msi_sent_cnt_o=1.
REQ-036 MSI mode, mmenable=0, src[0] and src[2] pulse in the same cycle, holdoff=5 -> two messages, both di=0, order 0 then 2, at least 5 idle cycles between them.
REQ-037 src[1] pulses in the acceptance cycle of source 1 -> pending[1] stays 1 and a second message is sent.
REQ-038 Legacy mode, src[2] pulses -> assert handshake; irq_ack_i[2] -> deassert handshake; cfg_interrupt_assert_n_o is 0 and then 1 during the two requests.
REQ-039 msienable 0->1 while in INTX_ON -> deassert handshake completes first, then MSI for the still-pending source; cfg_interrupt_n_o is never released before rdy.
REQ-040 Reset during MSI_REQ -> all outputs at reset values on the next edge; no request after release unless a new source event occurs.
